// File: rtl/mem_ctl_pkg.sv
// Shared types and default widths for the main-memory access controller.
// Used by mem_access_ctrl and mem_ctl_rd_pipe.
package mem_ctl_pkg;
    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 32;
    localparam int MEM_DEPTH_DEF = 101;
    localparam int BURST_MAX_DEF = 16;
    localparam int LEN_W_DEF     = $clog2(BURST_MAX_DEF + 1);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_ISS,
        RD_TAIL
    } state_t;
endpackage

// File: rtl/mem_ctl_rd_pipe.sv
// Read-return pipeline: tracks issued read beats through the memory's one-cycle
// latency, then captures the returned word into a registered response.
module mem_ctl_rd_pipe #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic              issue_last,
    input  logic [DATA_W-1:0] data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last
);

    // Stage 1 is high in the cycle memory presents the word for an issued address.
    logic              cap_valid_reg;
    logic              cap_last_reg;
    logic              rsp_valid_reg;
    logic              rsp_last_reg;
    logic [DATA_W-1:0] rsp_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid_reg <= 1'b0;
            cap_last_reg  <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_last_reg  <= 1'b0;
            rsp_data_reg  <= '0;
        end else begin
            cap_valid_reg <= issue;
            cap_last_reg  <= issue & issue_last;
            rsp_valid_reg <= cap_valid_reg;
            rsp_last_reg  <= cap_last_reg;
            rsp_data_reg  <= cap_valid_reg ? data : '0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_last  = rsp_last_reg;
    assign rsp_data  = rsp_data_reg;

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator for the main-memory port: single-beat writes and 1..BURST_MAX word read bursts.
// Optional range rejection of requests is enabled by defining MEMCTL_BOUNDS_CHECK_EN.
module mem_access_ctrl
    import mem_ctl_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int LEN_W     = $clog2(BURST_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] input_data,
    input  logic [DATA_W-1:0] data
);

`ifdef MEMCTL_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif
    localparam int AW1 = ADDR_W + 1;

    state_t            state_reg, state_next;
    logic              ready_reg, ready_next;
    logic [LEN_W-1:0]  remain_reg, remain_next;
    logic [ADDR_W-1:0] address_reg, address_next;
    logic              mem_read_reg, mem_read_next;
    logic              mem_write_reg, mem_write_next;
    logic [DATA_W-1:0] input_data_reg, input_data_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    logic              accept;
    logic [LEN_W-1:0]  len_eff;
    logic [AW1-1:0]    start_ext;
    logic [AW1-1:0]    end_ext;
    logic              out_of_range;
    logic              reject;
    logic              issue_last;
    logic              pipe_last;

    assign accept  = req_valid & ready_reg;
    assign len_eff = (req_len > LEN_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : req_len;

    // One extra bit so start+len-1 cannot wrap when judging the burst end.
    assign start_ext    = {1'b0, req_addr};
    assign end_ext      = start_ext + AW1'(len_eff) - AW1'(1);
    assign out_of_range = (start_ext >= AW1'(MEM_DEPTH)) ||
                          (!req_we && (len_eff != '0) && (end_ext >= AW1'(MEM_DEPTH)));
    assign reject       = BOUNDS_EN && out_of_range;

    assign issue_last = (state_reg == RD_ISS) && (remain_reg == '0);

    always_comb begin
        state_next      = state_reg;
        remain_next     = remain_reg;
        address_next    = '0;
        mem_read_next   = 1'b0;
        mem_write_next  = 1'b0;
        input_data_next = '0;
        done_next       = 1'b0;
        err_next        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (reject) begin
                        done_next = 1'b1;
                        err_next  = 1'b1;
                    end else if (req_we) begin
                        address_next    = req_addr;
                        input_data_next = req_wdata;
                        mem_write_next  = 1'b1;
                        state_next      = WR;
                    end else if (len_eff == '0) begin
                        done_next = 1'b1;
                    end else begin
                        address_next  = req_addr;
                        mem_read_next = 1'b1;
                        remain_next   = len_eff - LEN_W'(1);
                        state_next    = RD_ISS;
                    end
                end
            end
            WR: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            RD_ISS: begin
                if (remain_reg == '0) begin
                    state_next = RD_TAIL;
                end else begin
                    address_next  = address_reg + ADDR_W'(1);
                    mem_read_next = 1'b1;
                    remain_next   = remain_reg - LEN_W'(1);
                end
            end
            RD_TAIL: begin
                if (pipe_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        ready_next = (state_next == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            ready_reg      <= 1'b0;
            remain_reg     <= '0;
            address_reg    <= '0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            input_data_reg <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ready_reg      <= ready_next;
            remain_reg     <= remain_next;
            address_reg    <= address_next;
            mem_read_reg   <= mem_read_next;
            mem_write_reg  <= mem_write_next;
            input_data_reg <= input_data_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    mem_ctl_rd_pipe #(
        .DATA_W(DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (mem_read_reg),
        .issue_last(issue_last),
        .data      (data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (pipe_last)
    );

    // Read completion is signalled by the final beat leaving the pipe.
    assign rsp_last   = pipe_last;
    assign done       = done_reg | pipe_last;
    assign err        = err_reg;
    assign req_ready  = ready_reg;
    assign address    = address_reg;
    assign mem_read   = mem_read_reg;
    assign mem_write  = mem_write_reg;
    assign input_data = input_data_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a word-indexed memory model and a
// cycle-timing reference derived from request acceptance.
module tb_mem_access_ctrl;

`ifdef MEMCTL_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif
    localparam int MEM_DEPTH = 101;
    localparam int BURST_MAX = 16;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [4:0]  req_len;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        done;
    logic        err;
    logic [31:0] address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] input_data;
    logic [31:0] data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem     [0:127];
    logic [31:0] ref_mem [0:127];
    bit          known   [0:127];

    mem_access_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .done      (done),
        .err       (err),
        .address   (address),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .input_data(input_data),
        .data      (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main memory: registered read, one cycle after mem_read.
    always @(posedge clk) begin
        if (mem_write) mem[address[6:0]] <= input_data;
        if (mem_read) data <= mem[address[6:0]];
    end

    task automatic run_req(input bit we, input logic [31:0] addr, input logic [4:0] len,
                           input logic [31:0] wdata);
        int          leff;
        int          done_k;
        int          ready_k;
        int          w;
        bit          rej;
        bit          rd;
        bit          exp_mr, exp_mw, exp_rv, exp_last, exp_done, exp_err, exp_ready;
        logic [31:0] exp_addr;
        logic [31:0] idx;
        leff = (int'(len) > BURST_MAX) ? BURST_MAX : int'(len);
        rej  = BOUNDS_EN && ((addr >= MEM_DEPTH) ||
               (!we && leff > 0 && (longint'(addr) + leff - 1 >= MEM_DEPTH)));
        rd   = !we && !rej && leff > 0;
        if (rej || (!we && leff == 0)) begin
            done_k = 1; ready_k = 1;
        end else if (we) begin
            done_k = 2; ready_k = 2;
        end else begin
            done_k = leff + 2; ready_k = leff + 3;
        end
        w = 0;
        while (req_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
            return;
        end
        $display("txn we=%0d addr=%0d len=%0d wdata=%h reject=%0d", we, addr, len, wdata, rej);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
        req_len = 5'($urandom); req_wdata = $urandom;
        if (we && !rej) begin
            ref_mem[addr[6:0]] = wdata;
            known[addr[6:0]]   = 1'b1;
        end
        for (int k = 1; k <= ready_k; k++) begin
            exp_mr    = rd && k <= leff;
            exp_mw    = we && !rej && k == 1;
            exp_addr  = exp_mr ? addr + 32'(k - 1) : (exp_mw ? addr : 32'd0);
            exp_rv    = rd && k >= 3 && k <= leff + 2;
            exp_last  = rd && k == leff + 2;
            exp_done  = (k == done_k);
            exp_err   = rej && k == 1;
            exp_ready = (k >= ready_k);
            checks++;
            if (mem_read !== exp_mr) begin
                failures++;
                $display("FAIL mem_read k=%0d addr=%0d: got %b required %b", k, addr, mem_read, exp_mr);
            end
            checks++;
            if (mem_write !== exp_mw) begin
                failures++;
                $display("FAIL mem_write k=%0d addr=%0d: got %b required %b", k, addr, mem_write, exp_mw);
            end
            checks++;
            if (address !== exp_addr) begin
                failures++;
                $display("FAIL address k=%0d: got %0d required %0d", k, address, exp_addr);
            end
            if (exp_mw) begin
                checks++;
                if (input_data !== wdata) begin
                    failures++;
                    $display("FAIL input_data: got %h required %h", input_data, wdata);
                end
            end
            checks++;
            if (rsp_valid !== exp_rv) begin
                failures++;
                $display("FAIL rsp_valid k=%0d addr=%0d: got %b required %b", k, addr, rsp_valid, exp_rv);
            end
            if (exp_rv) begin
                idx = addr + 32'(k - 3);
                if (idx < 128 && known[idx[6:0]]) begin
                    checks++;
                    if (rsp_data !== ref_mem[idx[6:0]]) begin
                        failures++;
                        $display("FAIL rsp_data word=%0d: got %h required %h", idx, rsp_data, ref_mem[idx[6:0]]);
                    end
                end
            end
            checks++;
            if (rsp_last !== exp_last) begin
                failures++;
                $display("FAIL rsp_last k=%0d: got %b required %b", k, rsp_last, exp_last);
            end
            checks++;
            if (done !== exp_done) begin
                failures++;
                $display("FAIL done k=%0d: got %b required %b", k, done, exp_done);
            end
            checks++;
            if (err !== exp_err) begin
                failures++;
                $display("FAIL err k=%0d: got %b required %b", k, err, exp_err);
            end
            checks++;
            if (req_ready !== exp_ready) begin
                failures++;
                $display("FAIL req_ready k=%0d: got %b required %b", k, req_ready, exp_ready);
            end
            if (k < ready_k) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_read, mem_write, rsp_valid, rsp_last, done, err} !== 6'b0 ||
            address !== 32'd0 || input_data !== 32'd0 || rsp_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: rd=%b wr=%b rv=%b last=%b done=%b err=%b addr=%h required all 0",
                     mem_read, mem_write, rsp_valid, rsp_last, done, err, address);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b required 1", req_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < MEM_DEPTH; a++) run_req(1'b1, 32'(a), 5'd0, $urandom);
    endtask

    task automatic test_write_readback();
        run_req(1'b1, 32'd50, 5'd0, 32'hDEAD);
        run_req(1'b0, 32'd50, 5'd1, 32'd0);
    endtask

    task automatic test_preload_read();
        run_req(1'b1, 32'd19, 5'd0, 32'd14);
        run_req(1'b1, 32'd20, 5'd0, 32'd15);
        run_req(1'b1, 32'd21, 5'd0, 32'd11);
        run_req(1'b0, 32'd19, 5'd3, 32'd0);
    endtask

    task automatic test_burst_max();
        run_req(1'b0, 32'd0, 5'(BURST_MAX), 32'd0);
    endtask

    task automatic test_len_zero_clamp();
        run_req(1'b0, 32'd7, 5'd0, 32'd0);
        run_req(1'b0, 32'd40, 5'd20, 32'd0);
    endtask

    task automatic test_random();
        bit we;
        int a;
        int l;
        int le;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, MEM_DEPTH - 1);
            l  = $urandom_range(0, 20);
            le = (l > BURST_MAX) ? BURST_MAX : l;
            if (!we && le > 0 && a + le > MEM_DEPTH) a = MEM_DEPTH - le;
            run_req(we, 32'(a), 5'(l), $urandom);
        end
    endtask

    task automatic test_reset_midburst();
        int w;
        bit bad;
        w = 0;
        while (req_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        $display("txn reset during read addr=10 len=8");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd10; req_len = 5'd8;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL midburst_beat2: rsp_valid=%b required 1", rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write, rsp_valid, rsp_last, done, err} !== 6'b0 ||
            address !== 32'd0 || rsp_data !== 32'd0) begin
            failures++;
            $display("FAIL midburst_reset: rd=%b wr=%b rv=%b last=%b done=%b addr=%h required all 0",
                     mem_read, mem_write, rsp_valid, rsp_last, done, address);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || mem_read !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL midburst_leftover: activity seen after reset, required none");
        end
        run_req(1'b0, 32'd30, 5'd4, 32'd0);
    endtask

    task automatic test_bounds();
        run_req(1'b0, 32'd99, 5'd3, 32'd0);
        run_req(1'b1, 32'd101, 5'd0, 32'h1234_5678);
        run_req(1'b0, 32'd98, 5'd3, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = '0;
            known[i]   = 1'b0;
        end
        test_reset();
        test_back_to_back();
        test_write_readback();
        test_preload_read();
        test_burst_max();
        test_len_zero_clamp();
        test_random();
        test_reset_midburst();
        test_bounds();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
